a0_uart_logger: RTL
===================

Name: a0_uart_logger

Overview:
- Downstream consumer of the CPU core's a0 output; watches a0 every cycle and queues each new value.
- Serialises queued values onto a single UART TX line (8N1, LSB first) for off-chip observation of program results.
- Sits beside the core in the FPGA/board top level, on the same clock.
- Provides a small FIFO so that bursts of a0 updates are not lost while a byte is being shifted out.

Parameters:
- DATA_WIDTH, 32, width of the observed a0 value; must be a multiple of 8.
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); minimum 2.
- FIFO_DEPTH, 4, number of queued a0 samples; power of two, minimum 2.

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- rst, input, 1, asynchronous active-low reset.
- en, input, 1, logging enable; when low, no new samples are captured (transmission in progress continues).
- a0, input, DATA_WIDTH, observed register a0 from the core.
- tx, output, 1, UART serial line; idles high.
- busy, output, 1, high while a frame is being shifted or the FIFO is non-empty.
- overflow, output, 1, sticky; set when a sample is dropped because the FIFO is full.
- level, output, $clog2(FIFO_DEPTH)+1, current FIFO occupancy.

Behaviour:
- Reset (rst low, asynchronous): tx=1, busy=0, overflow=0, level=0, prev_a0=0, FSM=IDLE, counters=0, FIFO pointers=0.
- Change detect: each cycle with en=1 and a0 != prev_a0, push a0 into the FIFO; prev_a0 updates to a0 every cycle regardless of en.
  - A nonzero a0 in the first cycle after reset therefore logs once.
- Push latency: the sample is visible in level on the next edge.
- FIFO full and push requested without a same-cycle pop: sample dropped, overflow set (cleared only by reset), level unchanged.
- Simultaneous push and pop:
  - accepted even when full; level unchanged.
  - When empty, push and pop never coincide; a pop requires a non-empty FIFO.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If FIFO non-empty, pop the head into a DATA_WIDTH shift word, byte_idx=0, go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, load byte = word[7:0], go to DATA.
  - DATA: tx=byte[bit_idx], LSB first, CLKS_PER_BIT cycles per bit, 8 bits, then go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles.
    - If byte_idx < DATA_WIDTH/8-1: increment byte_idx, shift word right by 8, go to START.
    - Otherwise return to IDLE.
- Frame order: a 32-bit value is sent as 4 back-to-back frames, least significant byte first, with no idle gap between frames.
- Bit timing: baud counter counts 0..CLKS_PER_BIT-1 and restarts on every state/bit change; tx is registered (no glitches).
- busy = (FSM != IDLE) || (level != 0).
- en deasserted mid-word: current word completes, queued words still drain.
- rst asserted mid-frame: tx returns high immediately; queued data is lost.

Optional Feature:
- Macro HEX_ASCII_EN.
  - Defined: each sample is sent as DATA_WIDTH/4 ASCII hex characters, most significant nibble first, uppercase '0'-'9'/'A'-'F', followed by 0x0A. A 32-bit value gives 9 frames.
  - Undefined: raw binary, DATA_WIDTH/8 frames, LSB byte first.
  - FIFO behaviour is identical in both builds.

Decomposition:
- Package a0_logger_pkg holds:
  - typedef enum for IDLE/START/DATA/STOP;
  - localparams UART_IDLE=1'b1, START_BIT=1'b0, ASCII_NL=8'h0A;
  - a function that maps a nibble to its ASCII hex character.
- One sub-module, sync_fifo (WIDTH, DEPTH): push/pop/full/empty/level, same clk/rst convention, registered pointers with an extra wrap bit.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4, raw build unless stated):
- Reset then hold a0=0 for 200 cycles -> tx stays 1, busy=0, level=0.
- a0 0→0x12345678 for one edge -> 4 frames with bytes 0x78,0x56,0x34,0x12; each frame is 40 cycles with start low and stop high; busy falls after 160 cycles.
- a0 stepped 1,2,3,4,5,6 on consecutive cycles -> FIFO accepts 1..4 (first popped immediately, so 5 also fits), 6 dropped, overflow=1; transmitted values are 1,2,3,4,5 in order.
- en=0 while a0 changes to 0xDEADBEEF -> no frames sent, level=0; then en=1 with a0 unchanged -> still nothing sent.
- rst pulsed low mid-DATA of the second byte -> tx=1 in the same cycle, level=0, overflow=0; after release, the next a0 change transmits cleanly.
- HEX_ASCII_EN build, a0=0x00ABCDEF -> frames '0','0','A','B','C','D','E','F',0x0A (0x30,0x30,0x41,0x42,0x43,0x44,0x45,0x46,0x0A).

Source files
------------

// File: rtl/a0_logger_pkg.sv
// Shared types and constants for the a0 UART logger: transmitter states, line levels
// and the nibble-to-ASCII-hex mapping used by the HEX_ASCII_EN build.
package a0_logger_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam logic       UART_IDLE = 1'b1;
    localparam logic       START_BIT = 1'b0;
    localparam logic [7:0] ASCII_NL  = 8'h0A;

    // '0'..'9' live at 0x30.., 'A'..'F' at 0x41.. (0x37 + 10)
    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            hex_ascii = 8'h30 + {4'h0, nib};
        end else begin
            hex_ascii = 8'h37 + {4'h0, nib};
        end
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with first-word-fall-through head; pointers carry an extra wrap bit
// so full/empty/level fall straight out of the pointer difference.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic                    pop,
    input  logic [WIDTH-1:0]        wr_data,
    output logic [WIDTH-1:0]        rd_data,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic             do_push;
    logic             do_pop;

    assign level   = wr_ptr_reg - rd_ptr_reg;
    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (level == (AW + 1)'(DEPTH));
    assign rd_data = mem[rd_ptr_reg[AW-1:0]];

    // A pop frees the head slot this cycle, so a full FIFO still takes a simultaneous push.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

endmodule

// File: rtl/a0_uart_logger.sv
// Watches the core's a0 register, queues every new value and streams it out on an 8N1 UART.
// Build option HEX_ASCII_EN: send uppercase ASCII hex (MS nibble first) plus newline instead of raw LSB-first bytes.
module a0_uart_logger
    import a0_logger_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic [DATA_WIDTH-1:0]        a0,
    output logic                         tx,
    output logic                         busy,
    output logic                         overflow,
    output logic [$clog2(FIFO_DEPTH):0]  level
);

`ifdef HEX_ASCII_EN
    localparam int FRAMES = DATA_WIDTH / 4 + 1;
`else
    localparam int FRAMES = DATA_WIDTH / 8;
`endif
    localparam int IDX_W = $clog2(FRAMES + 1);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    uart_state_t           state_reg, state_next;
    logic [CNT_W-1:0]      cnt_reg, cnt_next;
    logic [2:0]            bit_idx_reg, bit_idx_next;
    logic [IDX_W-1:0]      byte_idx_reg, byte_idx_next;
    logic [DATA_WIDTH-1:0] word_reg, word_next;
    logic [7:0]            byte_reg, byte_next;
    logic                  tx_reg, tx_next;
    logic [DATA_WIDTH-1:0] prev_a0_reg;
    logic                  overflow_reg;

    logic                  push;
    logic                  pop;
    logic                  bit_done;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_head;
    logic [7:0]            frame_byte;

    assign push = en && (a0 != prev_a0_reg);

    sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .wr_data (a0),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (level)
    );

`ifdef HEX_ASCII_EN
    // Word shifts left a nibble per frame; the last frame of each sample is the newline.
    assign frame_byte = (byte_idx_reg == IDX_W'(FRAMES - 1)) ? ASCII_NL
                                                             : hex_ascii(word_reg[DATA_WIDTH-1 -: 4]);
`else
    assign frame_byte = word_reg[7:0];
`endif

    assign bit_done = (cnt_reg == CNT_W'(CLKS_PER_BIT - 1));

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        bit_idx_next  = bit_idx_reg;
        byte_idx_next = byte_idx_reg;
        word_next     = word_reg;
        byte_next     = byte_reg;
        tx_next       = UART_IDLE;
        pop           = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!fifo_empty) begin
                    pop           = 1'b1;
                    word_next     = fifo_head;
                    byte_idx_next = '0;
                    cnt_next      = '0;
                    state_next    = START;
                end
            end
            START: begin
                tx_next = START_BIT;
                if (bit_done) begin
                    cnt_next     = '0;
                    bit_idx_next = '0;
                    byte_next    = frame_byte;
                    state_next   = DATA;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            DATA: begin
                tx_next = byte_reg[bit_idx_reg];
                if (bit_done) begin
                    cnt_next = '0;
                    if (bit_idx_reg == 3'd7) begin
                        state_next = STOP;
                    end else begin
                        bit_idx_next = bit_idx_reg + 1'b1;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            STOP: begin
                tx_next = UART_IDLE;
                if (bit_done) begin
                    cnt_next = '0;
                    if (byte_idx_reg < IDX_W'(FRAMES - 1)) begin
                        byte_idx_next = byte_idx_reg + 1'b1;
`ifdef HEX_ASCII_EN
                        word_next     = word_reg << 4;
`else
                        word_next     = word_reg >> 8;
`endif
                        state_next    = START;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            bit_idx_reg  <= '0;
            byte_idx_reg <= '0;
            word_reg     <= '0;
            byte_reg     <= '0;
            tx_reg       <= UART_IDLE;
            prev_a0_reg  <= '0;
            overflow_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            bit_idx_reg  <= bit_idx_next;
            byte_idx_reg <= byte_idx_next;
            word_reg     <= word_next;
            byte_reg     <= byte_next;
            tx_reg       <= tx_next;
            prev_a0_reg  <= a0;
            if (push && fifo_full && !pop) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    assign tx       = tx_reg;
    assign overflow = overflow_reg;
    assign busy     = (state_reg != IDLE) || (level != '0);

endmodule
